// File: rtl/voice_allocator.sv
// Polyphonic voice allocator. It turns edges on the held-key table into a stream of
// voice assignments, releases and round-robin steals, and services one event per clock.
module voice_allocator #(
  parameter int NUM_KEYS   = 21,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         key_table,
  output logic [NUM_VOICES-1:0]       voice_valid,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_on,
  output logic [NUM_VOICES-1:0]       voice_off,
  output logic                        busy,
  output logic [7:0]                  steal_cnt
);

  localparam int VP_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [NUM_KEYS-1:0] ONE_KEY    = {{(NUM_KEYS-1){1'b0}}, 1'b1};
  localparam logic [VP_W-1:0]     LAST_VOICE = VP_W'(NUM_VOICES - 1);

  logic [NUM_KEYS-1:0]         key_prev_q, pend_on_q, pend_off_q;
  logic [NUM_KEYS-1:0]         pend_on_d, pend_off_d;
  logic [NUM_VOICES-1:0]       voice_valid_q, voice_valid_d;
  logic [NUM_VOICES*KEY_W-1:0] voice_key_q, voice_key_d;
  logic [NUM_VOICES-1:0]       voice_on_q, voice_on_d;
  logic [NUM_VOICES-1:0]       voice_off_q, voice_off_d;
  logic [VP_W-1:0]             steal_ptr_q, steal_ptr_d;
  logic [7:0]                  steal_cnt_q, steal_cnt_d;

  logic [NUM_KEYS-1:0]   rise_s, fall_s, eff_on_s, eff_off_s;
  logic [KEY_W-1:0]      off_key_s, on_key_s;
  logic [NUM_VOICES-1:0] off_hit_s, on_hit_s, free_oh_s, steal_oh_s, load_oh_s;
  logic                  free_found_s;

  function automatic logic [KEY_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] vec);
    logic [KEY_W-1:0] idx;
    idx = {KEY_W{1'b0}};
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = KEY_W'(i);
      end
    end
    return idx;
  endfunction

  // Edge detection, merge with pending queues and per-voice lookups
  always_comb begin
    rise_s       = key_table & ~key_prev_q;
    fall_s       = ~key_table & key_prev_q;
    eff_on_s     = pend_on_q | rise_s;
    eff_off_s    = pend_off_q | fall_s;
    off_key_s    = lowest_set(eff_off_s);
    on_key_s     = lowest_set(eff_on_s);
    off_hit_s    = {NUM_VOICES{1'b0}};
    on_hit_s     = {NUM_VOICES{1'b0}};
    free_oh_s    = {NUM_VOICES{1'b0}};
    steal_oh_s   = {NUM_VOICES{1'b0}};
    free_found_s = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      off_hit_s[v]  = voice_valid_q[v] && (voice_key_q[v*KEY_W +: KEY_W] == off_key_s);
      on_hit_s[v]   = voice_valid_q[v] && (voice_key_q[v*KEY_W +: KEY_W] == on_key_s);
      steal_oh_s[v] = (VP_W'(v) == steal_ptr_q);
      if (!voice_valid_q[v] && !free_found_s) begin
        free_oh_s[v] = 1'b1;
        free_found_s = 1'b1;
      end else begin
        free_oh_s[v] = 1'b0;
      end
    end
  end

  // Service one event: a release if any is queued, otherwise a press
  always_comb begin
    pend_on_d     = eff_on_s;
    pend_off_d    = eff_off_s;
    voice_valid_d = voice_valid_q;
    voice_key_d   = voice_key_q;
    voice_on_d    = {NUM_VOICES{1'b0}};
    voice_off_d   = {NUM_VOICES{1'b0}};
    steal_ptr_d   = steal_ptr_q;
    steal_cnt_d   = steal_cnt_q;
    load_oh_s     = {NUM_VOICES{1'b0}};
    if (|eff_off_s) begin
      pend_off_d    = eff_off_s & ~(ONE_KEY << off_key_s);
      voice_valid_d = voice_valid_q & ~off_hit_s;
      voice_off_d   = off_hit_s;
    end else if (|eff_on_s) begin
      pend_on_d = eff_on_s & ~(ONE_KEY << on_key_s);
      if (!key_table[on_key_s] || (|on_hit_s)) begin
        // Key already let go, or it already sounds on a voice: drop it.
        load_oh_s = {NUM_VOICES{1'b0}};
      end else if (free_found_s) begin
        load_oh_s     = free_oh_s;
        voice_valid_d = voice_valid_q | free_oh_s;
        voice_on_d    = free_oh_s;
      end else begin
        load_oh_s   = steal_oh_s;
        voice_on_d  = steal_oh_s;
        voice_off_d = steal_oh_s;
        steal_ptr_d = (steal_ptr_q == LAST_VOICE) ? {VP_W{1'b0}} : steal_ptr_q + VP_W'(1);
        steal_cnt_d = (steal_cnt_q == 8'hFF) ? steal_cnt_q : steal_cnt_q + 8'd1;
      end
    end else begin
      load_oh_s = {NUM_VOICES{1'b0}};
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (load_oh_s[v]) begin
        voice_key_d[v*KEY_W +: KEY_W] = on_key_s;
      end else begin
        voice_key_d[v*KEY_W +: KEY_W] = voice_key_q[v*KEY_W +: KEY_W];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev_q    <= {NUM_KEYS{1'b0}};
      pend_on_q     <= {NUM_KEYS{1'b0}};
      pend_off_q    <= {NUM_KEYS{1'b0}};
      voice_valid_q <= {NUM_VOICES{1'b0}};
      voice_key_q   <= {(NUM_VOICES*KEY_W){1'b0}};
      voice_on_q    <= {NUM_VOICES{1'b0}};
      voice_off_q   <= {NUM_VOICES{1'b0}};
      steal_ptr_q   <= {VP_W{1'b0}};
      steal_cnt_q   <= 8'd0;
    end else begin
      key_prev_q    <= key_table;
      pend_on_q     <= pend_on_d;
      pend_off_q    <= pend_off_d;
      voice_valid_q <= voice_valid_d;
      voice_key_q   <= voice_key_d;
      voice_on_q    <= voice_on_d;
      voice_off_q   <= voice_off_d;
      steal_ptr_q   <= steal_ptr_d;
      steal_cnt_q   <= steal_cnt_d;
    end
  end

  assign voice_valid = voice_valid_q;
  assign voice_key   = voice_key_q;
  assign voice_on    = voice_on_q;
  assign voice_off   = voice_off_q;
  assign busy        = |(pend_on_q | pend_off_q);
  assign steal_cnt   = steal_cnt_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: a table of per-cycle vectors fed through
// an expectation queue, followed by a steal-counter saturation sequence.
module tb_voice_allocator;

  localparam int NK = 21;
  localparam int NV = 4;
  localparam int KW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [NK-1:0]   key_table;
  logic [NV-1:0]   voice_valid, voice_on, voice_off;
  logic [NV*KW-1:0] voice_key;
  logic            busy;
  logic [7:0]      steal_cnt;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW)) dut (
    .clk(clk), .rst(rst), .key_table(key_table),
    .voice_valid(voice_valid), .voice_key(voice_key),
    .voice_on(voice_on), .voice_off(voice_off),
    .busy(busy), .steal_cnt(steal_cnt)
  );

  typedef struct packed {
    logic            rst;
    logic [NK-1:0]   kt;
    logic [NV-1:0]   valid;
    logic [NV*KW-1:0] keys;
    logic [NV-1:0]   on;
    logic [NV-1:0]   off;
    logic            busy;
    logic [7:0]      cnt;
  } vec_t;

  vec_t tbl_q[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [NV*KW-1:0] kp(input int k3, input int k2, input int k1, input int k0);
    return {KW'(k3), KW'(k2), KW'(k1), KW'(k0)};
  endfunction

  task automatic add(input logic r, input logic [NK-1:0] kt, input logic [NV-1:0] va,
                     input logic [NV*KW-1:0] ks, input logic [NV-1:0] on,
                     input logic [NV-1:0] off, input logic b, input logic [7:0] c);
    vec_t t;
    t.rst = r; t.kt = kt; t.valid = va; t.keys = ks;
    t.on = on; t.off = off; t.busy = b; t.cnt = c;
    tbl_q.push_back(t);
  endtask

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
    end
  endtask

  task automatic wait_idle(input int step);
    int c;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (busy && c < 64);
    chk("drain_busy", step, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   exp_cnt;
    rst = 1'b1;
    key_table = '0;

    // Single press and release of key 7
    add(1'b1, 21'h000000, 4'b0000, kp(0,0,0,0),   4'b0000, 4'b0000, 1'b0, 8'd0);
    add(1'b0, 21'h000080, 4'b0001, kp(0,0,0,7),   4'b0001, 4'b0000, 1'b0, 8'd0);
    add(1'b0, 21'h000080, 4'b0001, kp(0,0,0,7),   4'b0000, 4'b0000, 1'b0, 8'd0);
    add(1'b0, 21'h000000, 4'b0000, kp(0,0,0,7),   4'b0000, 4'b0001, 1'b0, 8'd0);
    add(1'b0, 21'h000000, 4'b0000, kp(0,0,0,7),   4'b0000, 4'b0000, 1'b0, 8'd0);
    // Three simultaneous presses drain over three cycles
    add(1'b0, 21'h000007, 4'b0001, kp(0,0,0,0),   4'b0001, 4'b0000, 1'b1, 8'd0);
    add(1'b0, 21'h000007, 4'b0011, kp(0,0,1,0),   4'b0010, 4'b0000, 1'b1, 8'd0);
    add(1'b0, 21'h000007, 4'b0111, kp(0,2,1,0),   4'b0100, 4'b0000, 1'b0, 8'd0);
    // Fill the bank, then steal voices 0 and 1
    add(1'b0, 21'h00000F, 4'b1111, kp(3,2,1,0),   4'b1000, 4'b0000, 1'b0, 8'd0);
    add(1'b0, 21'h00001F, 4'b1111, kp(3,2,1,4),   4'b0001, 4'b0001, 1'b0, 8'd1);
    add(1'b0, 21'h00003F, 4'b1111, kp(3,2,5,4),   4'b0010, 4'b0010, 1'b0, 8'd2);
    // Release key 2 and press key 9 together: release first, then reuse the freed voice
    add(1'b0, 21'h00023B, 4'b1011, kp(3,2,5,4),   4'b0000, 4'b0100, 1'b1, 8'd2);
    add(1'b0, 21'h00023B, 4'b1111, kp(3,9,5,4),   4'b0100, 4'b0000, 1'b0, 8'd2);
    // Key 3 released while its press is still queued
    add(1'b1, 21'h000000, 4'b0000, kp(0,0,0,0),   4'b0000, 4'b0000, 1'b0, 8'd0);
    add(1'b0, 21'h000000, 4'b0000, kp(0,0,0,0),   4'b0000, 4'b0000, 1'b0, 8'd0);
    add(1'b0, 21'h00000F, 4'b0001, kp(0,0,0,0),   4'b0001, 4'b0000, 1'b1, 8'd0);
    add(1'b0, 21'h000007, 4'b0001, kp(0,0,0,0),   4'b0000, 4'b0000, 1'b1, 8'd0);
    add(1'b0, 21'h000007, 4'b0011, kp(0,0,1,0),   4'b0010, 4'b0000, 1'b1, 8'd0);
    add(1'b0, 21'h000007, 4'b0111, kp(0,2,1,0),   4'b0100, 4'b0000, 1'b1, 8'd0);
    add(1'b0, 21'h000007, 4'b0111, kp(0,2,1,0),   4'b0000, 4'b0000, 1'b0, 8'd0);
    add(1'b0, 21'h000007, 4'b0111, kp(0,2,1,0),   4'b0000, 4'b0000, 1'b0, 8'd0);
    // Reset in the middle of a five-event drain, then re-allocate held keys
    add(1'b0, 21'h001F07, 4'b1111, kp(8,2,1,0),   4'b1000, 4'b0000, 1'b1, 8'd0);
    add(1'b0, 21'h001F07, 4'b1111, kp(8,2,1,9),   4'b0001, 4'b0001, 1'b1, 8'd1);
    add(1'b1, 21'h001F07, 4'b0000, kp(0,0,0,0),   4'b0000, 4'b0000, 1'b0, 8'd0);
    add(1'b0, 21'h001F07, 4'b0001, kp(0,0,0,0),   4'b0001, 4'b0000, 1'b1, 8'd0);
    add(1'b0, 21'h001F07, 4'b0011, kp(0,0,1,0),   4'b0010, 4'b0000, 1'b1, 8'd0);
    add(1'b0, 21'h001F07, 4'b0111, kp(0,2,1,0),   4'b0100, 4'b0000, 1'b1, 8'd0);
    add(1'b0, 21'h001F07, 4'b1111, kp(8,2,1,0),   4'b1000, 4'b0000, 1'b1, 8'd0);
    add(1'b0, 21'h001F07, 4'b1111, kp(8,2,1,9),   4'b0001, 4'b0001, 1'b1, 8'd1);
    add(1'b0, 21'h001F07, 4'b1111, kp(8,2,10,9),  4'b0010, 4'b0010, 1'b1, 8'd2);
    add(1'b0, 21'h001F07, 4'b1111, kp(8,11,10,9), 4'b0100, 4'b0100, 1'b1, 8'd3);
    add(1'b0, 21'h001F07, 4'b1111, kp(12,11,10,9),4'b1000, 4'b1000, 1'b0, 8'd4);

    foreach (tbl_q[i]) begin
      @(negedge clk);
      rst       = tbl_q[i].rst;
      key_table = tbl_q[i].kt;
      exp_q.push_back(tbl_q[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk("voice_valid", i, 32'(voice_valid), 32'(e.valid));
      chk("voice_key",   i, 32'(voice_key),   32'(e.keys));
      chk("voice_on",    i, 32'(voice_on),    32'(e.on));
      chk("voice_off",   i, 32'(voice_off),   32'(e.off));
      chk("busy",        i, 32'(busy),        32'(e.busy));
      chk("steal_cnt",   i, 32'(steal_cnt),   32'(e.cnt));
    end

    // Each all-keys round steals 17 times (21 keys, 4 voices); counter saturates at 255
    @(negedge clk);
    rst = 1'b1;
    key_table = '0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      @(negedge clk);
      key_table = {NK{1'b1}};
      wait_idle(r);
      exp_cnt = (17 * r > 255) ? 255 : 17 * r;
      chk("steal_sat", r, 32'(steal_cnt), 32'(exp_cnt));
      @(negedge clk);
      key_table = '0;
      wait_idle(r);
      chk("all_released", r, 32'(voice_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
